// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble control from Tuse/Tnew comparison, mult/div busy
// countdown and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        E_flush,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic stall_rs, stall_rt, stall_md;

    // A producer only blocks when its result arrives later than the consumer needs it
    assign stall_rs = (D_rs != 5'd0) && (D_tuse_rs != 2'd3) &&
                      ((E_wa == D_rs && E_tnew > D_tuse_rs) || (M_wa == D_rs && M_tnew > D_tuse_rs));
    assign stall_rt = (D_rt != 5'd0) && (D_tuse_rt != 2'd3) &&
                      ((E_wa == D_rt && E_tnew > D_tuse_rt) || (M_wa == D_rt && M_tnew > D_tuse_rt));
    assign stall_md = D_is_md && (md_busy || E_md_start);
    assign stall    = stall_rs | stall_rt | stall_md;
    assign E_flush  = stall;
    assign md_busy  = cnt != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A start seen while busy is ignored; the countdown simply continues
    always_comb begin
        state_nx = (state == IDLE) ? (E_md_start ? BUSY : IDLE)
                                   : ((cnt == CNT_W'(1)) ? IDLE : BUSY);
        cnt_nx   = (state == IDLE) ? (E_md_start ? (E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) : cnt)
                                   : cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard-driven bench; expectations queued per cycle, drained
// against the DUT one ns after the inputs settle in the low clock phase.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic [4:0] D_rs, D_rt, E_wa, M_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic D_is_md, E_md_start, E_md_div;
    logic stall, E_flush, md_busy;
    logic [31:0] stall_cycles;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_sc = '0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_is_md(D_is_md), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .stall(stall), .E_flush(E_flush), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    function automatic logic [31:0] obs(int sel);
        return sel == 0 ? {31'd0, stall} : sel == 1 ? {31'd0, E_flush} :
               sel == 2 ? {31'd0, md_busy} : stall_cycles;
    endfunction

    task automatic clr();
        D_rs = 0; D_rt = 0; D_tuse_rs = 0; D_tuse_rt = 0; D_is_md = 0;
        E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0; E_md_start = 0; E_md_div = 0;
    endtask

    // Queue this cycle's expected outputs, then advance the counter model for the coming edge
    task automatic push(string n, logic s, logic b);
        sb.push_back('{name: {n, "_stall"}, sel: 0, exp: {31'd0, s}});
        sb.push_back('{name: {n, "_flush"}, sel: 1, exp: {31'd0, s}});
        sb.push_back('{name: {n, "_busy"},  sel: 2, exp: {31'd0, b}});
        sb.push_back('{name: {n, "_cnt"},   sel: 3, exp: exp_sc});
        if (s && !reset && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1; clr();
        repeat (2) @(negedge clk);
        reset = 0;
        exp_sc = '0;
        push("reset", 0, 0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_chk++;
            if (obs(e.sel) !== e.exp) begin
                n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, obs(e.sel), e.exp);
            end
        end
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clr();
            D_rs = 8; D_tuse_rs = 0;
            E_wa = (c == 0) ? 5'd8 : 5'd0; E_tnew = (c == 0) ? 2'd2 : 2'd0;
            M_wa = (c == 0) ? 5'd0 : 5'd8; M_tnew = (c == 1) ? 2'd1 : 2'd0;
            push($sformatf("load_use%0d", c), c < 2, 0);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_chk++;
                if (obs(e.sel) !== e.exp) begin
                    n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_zero_unused();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); clr();
            case (c)
                0: begin D_rs = 0; E_wa = 0; E_tnew = 2; end
                1: begin D_rt = 9; D_tuse_rt = 3; E_wa = 9; E_tnew = 2; end
                2: begin D_rs = 0; M_wa = 0; M_tnew = 2; end
                3: begin D_rs = 8; E_wa = 7; E_tnew = 2; end
                default: begin D_rs = 9; E_wa = 9; E_tnew = 0; M_wa = 9; M_tnew = 0; end
            endcase
            push($sformatf("zero_unused%0d", c), 0, 0);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_chk++;
                if (obs(e.sel) !== e.exp) begin
                    n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_tuse_boundary();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); clr();
            case (c)
                0: begin D_rt = 5; D_tuse_rt = 1; E_wa = 5; E_tnew = 1; end
                1: begin D_rt = 5; D_tuse_rt = 1; E_wa = 5; E_tnew = 2; end
                2: begin D_rt = 5; D_tuse_rt = 1; M_wa = 5; M_tnew = 1; end
                3: begin D_rs = 6; D_tuse_rs = 1; M_wa = 6; M_tnew = 2; end
                default: begin D_rs = 6; D_rt = 6; D_tuse_rs = 2; D_tuse_rt = 2; E_wa = 6; E_tnew = 2; end
            endcase
            push($sformatf("tuse%0d", c), c == 1 || c == 3, 0);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_chk++;
                if (obs(e.sel) !== e.exp) begin
                    n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_mult();
        logic [31:0] base;
        base = exp_sc;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); clr();
            D_is_md = 1; E_md_start = (c == 0); E_md_div = 0;
            push($sformatf("mult%0d", c), c <= 5, c >= 1 && c <= 5);
            if (c == 6) sb.push_back('{name: "mult_sc_delta", sel: 3, exp: base + 32'd6});
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_chk++;
                if (obs(e.sel) !== e.exp) begin
                    n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_div_reset();
        for (int c = 0; c < 17; c++) begin
            @(negedge clk); clr();
            reset = (c == 4);
            E_md_start = (c == 0 || c == 5); E_md_div = 1;
            if (c == 5) exp_sc = '0;
            push($sformatf("div_rst%0d", c), 0, (c >= 1 && c <= 4) || (c >= 6 && c <= 15));
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_chk++;
                if (obs(e.sel) !== e.exp) begin
                    n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, obs(e.sel), e.exp);
                end
            end
        end
        reset = 0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 19; c++) begin
            @(negedge clk); clr();
            D_is_md = 1;
            E_md_start = (c == 0 || c == 3 || c == 7);
            E_md_div = (c != 0);
            push($sformatf("b2b%0d", c), c != 6 && c != 18, (c >= 1 && c <= 5) || (c >= 8 && c <= 17));
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_chk++;
                if (obs(e.sel) !== e.exp) begin
                    n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk); clr();
        D_rs = 3; E_wa = 3; E_tnew = 2;
        force dut.stall_cycles = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.stall_cycles;
        exp_sc = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clr();
            if (c < 2) begin D_rs = 3; E_wa = 3; E_tnew = 2; end
            push($sformatf("sat%0d", c), c < 2, 0);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_chk++;
                if (obs(e.sel) !== e.exp) begin
                    n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, obs(e.sel), e.exp);
                end
            end
        end
    endtask

    initial begin
        reset = 1; clr();
        test_reset();
        test_load_use();
        test_zero_unused();
        test_tuse_boundary();
        test_mult();
        test_div_reset();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/bubble controller for the 5-stage pipeline.
- Compares the D-stage operand use time (Tuse) against the result-ready time (Tnew) of the instructions in E and M. Drives the fetch-stage hold, the F/D register hold and the E-stage bubble insert.
- Owns the busy countdown for the multi-cycle mult/div unit and blocks D-stage HI/LO-class instructions while that unit is busy.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start
CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
D_rs  in  5  rs register index of the D-stage instruction
D_rt  in  5  rt register index of the D-stage instruction
D_tuse_rs  in  2  cycles until rs is consumed (0=D, 1=E, 2=M); 3 = rs not used
D_tuse_rt  in  2  same encoding, for rt
D_is_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
E_wa  in  5  destination register of the E-stage instruction; 0 = no write
E_tnew  in  2  cycles until the E-stage result is forwardable
M_wa  in  5  destination register of the M-stage instruction; 0 = no write
M_tnew  in  2  cycles until the M-stage result is forwardable, already decremented by the pipeline
E_md_start  in  1  an E-stage mult/div is issued this cycle
E_md_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
stall  out  1  hold PC and the F/D register (fetch-stage stall input)
E_flush  out  1  load a nop into the D/E register this cycle
md_busy  out  1  registered: mult/div unit is still computing
stall_cycles  out  32  registered count of cycles with stall=1

Behaviour:
- Combinational stall terms:
  - stall_rs = (D_rs!=0) && (D_tuse_rs!=3) && ((E_wa==D_rs && E_tnew>D_tuse_rs) || (M_wa==D_rs && M_tnew>D_tuse_rs)).
  - stall_rt is the same with D_rt and D_tuse_rt.
  - stall_md = D_is_md && (md_busy || E_md_start).
  - stall = stall_rs | stall_rt | stall_md.
  - E_flush = stall: always asserted together with stall, same cycle.
- Register 0 never causes a stall, whatever E_wa/M_wa/tnew values are presented.
- Tnew==0 in E or M never stalls; forwarding covers it.
- Busy counter (CNT_W bits), one state machine with states IDLE (cnt==0) and BUSY (cnt!=0):
  - IDLE and E_md_start=1: on the next edge cnt loads DIV_CYCLES if E_md_div=1, else MULT_CYCLES.
  - BUSY: cnt decrements by 1 each edge. When it reaches 0 the state returns to IDLE.
  - BUSY and E_md_start=1: the start is ignored and cnt keeps decrementing. This case is illegal by construction, because stall_md prevents it.
  - md_busy = (cnt != 0), taken directly from the register.
  - Latency: if the start is sampled at edge t, md_busy is 1 for exactly N cycles after t (N = MULT_CYCLES or DIV_CYCLES), then 0.
  - Back-to-back use: a mult/div that reaches D while md_busy=1 is released in the first cycle in which md_busy=0 and E_md_start=0.
- stall_cycles increments on every edge where stall=1 and saturates at 32'hFFFFFFFF.
- Reset at an edge, including mid-countdown: cnt=0, md_busy=0, stall_cycles=0.
- stall and E_flush are combinational, so after reset they follow the inputs only: 0 when all inputs are 0.
- The block holds no other state and adds no latency on the stall path.

Test Plan:
1. Load-use: D_rs=8, D_tuse_rs=0, E_wa=8, E_tnew=2 -> stall=1, E_flush=1. Next cycle M_wa=8, M_tnew=1 -> stall=1. Then M_tnew=0 -> stall=0.
2. Zero register and unused operand: D_rs=0, E_wa=0, E_tnew=2 -> stall=0. D_rt=9, D_tuse_rt=3, E_wa=9, E_tnew=2 -> stall=0.
3. Tuse boundary: D_rt=5, D_tuse_rt=1, E_wa=5 with E_tnew=1 -> stall=0; with E_tnew=2 -> stall=1.
4. Mult then mfhi: E_md_start=1, E_md_div=0 at edge t -> md_busy=1 for 5 cycles. D_is_md=1 stalls during the start cycle and all 5 busy cycles. stall_cycles advances by 6.
5. Div, then reset at the 4th busy cycle: start with E_md_div=1 -> md_busy high. Reset at the 4th busy cycle -> md_busy=0, stall_cycles=0 on the following cycle. Next div start -> a full 10-cycle busy window.
6. Saturation: force stall=1 for 2^32+3 cycles, or preload via a bench hierarchical force -> stall_cycles holds 32'hFFFFFFFF.
